dram_burst_reader: RTL and testbench

DRAM_BURST_READER -- requirements
Module: dram_burst_reader

---
 rtl/dram_burst_reader.sv | 121 ++++++++++++
 tb/tb_dram_burst_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_reader.sv
// Streams a burst of bytes from a one-cycle-latency memory port into a FWFT output buffer.
// First read one cycle after accept; reads stop when buffer plus in-flight read would exceed FIFO_DEPTH.
module dram_burst_reader #(
    parameter int A_WIDTH    = 20,
    parameter int D_WIDTH    = 8,
    parameter int L_WIDTH    = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [A_WIDTH-1:0] cmd_addr,
    input  logic [L_WIDTH-1:0] cmd_len,
    output logic               mem_ren,
    output logic [A_WIDTH-1:0] mem_raddr,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_last,
    output logic               done,
    output logic               busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [L_WIDTH-1:0] rem_q, rem_d;
    logic               inflight_q, inflight_last_q;
    logic               done_q;
    logic [D_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW:0]        occupancy;
    logic               accept, issue, push, pop, final_pop;

    assign accept    = cmd_valid && cmd_ready;
    // Credit counts the outstanding read so a full buffer can never be overrun.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign issue     = (state_q == RUN) && (rem_q != '0) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign push      = inflight_q;
    assign pop       = out_valid && out_ready;
    assign final_pop = pop && fifo_last_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && cmd_len != '0) state_d = RUN;
            RUN:     if (issue && rem_q == L_WIDTH'(1)) state_d = DRAIN;
            DRAIN:   if (final_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        mem_ren   = issue;
        mem_raddr = addr_q;
        out_valid = (count_q != '0);
        out_data  = fifo_mem_q[rd_ptr_q];
        out_last  = out_valid && fifo_last_q[rd_ptr_q];
        done      = done_q;
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (accept) begin
            addr_d = cmd_addr;
            rem_d  = cmd_len;
        end else if (issue) begin
            addr_d = addr_q + A_WIDTH'(1);
            rem_d  = rem_q - L_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fifo_last_q     <= '0;
        end else begin
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_q == L_WIDTH'(1));
            done_q          <= (accept && cmd_len == '0) || ((state_q == DRAIN) && final_pop);
            if (push) begin
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= mem_rdata;
    end
endmodule

// File: tb/tb_dram_burst_reader.sv
// Randomized and directed bursts against a queue-based reference of the byte stream and read addresses.
module tb_dram_burst_reader;
    localparam int AW = 20, DW = 8, LW = 12, DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          busy;

    always #5 clk = ~clk;

    dram_burst_reader #(.A_WIDTH(AW), .D_WIDTH(DW), .L_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .done(done), .busy(busy)
    );

    typedef struct packed { logic [7:0] d; logic l; } exp_t;

    exp_t          byte_q[$];
    logic [AW-1:0] addr_q[$];
    bit            model_idle = 1'b1;
    bit            exp_done = 1'b0;
    int            chk_cnt = 0, pass_cnt = 0;
    int            cyc = 0, accepts = 0, issued = 0, popped = 0;
    int            ren_in_burst = 0, pops_in_burst = 0;
    int            first_ren_cyc = 0, last_ren_cyc = 0, acc_cyc = 0, done_cyc = -1;
    int            rdy_mode = 0;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]};
    endfunction

    // Memory responder: valid data exactly one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ren) mem_rdata <= mem_byte(mem_raddr);
        else         mem_rdata <= DW'($urandom);
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic monitor();
        exp_t          e;
        logic [AW-1:0] ea, a;
        bit            nxt_done, idle_now;
        forever begin
            @(negedge clk);
            if (rst) begin
                check(!mem_ren && !out_valid && !out_last && !done && !busy && cmd_ready && mem_raddr == '0,
                      "reset_outputs", {mem_ren, out_valid, out_last, done, busy, cmd_ready}, 6'b000001);
                byte_q.delete(); addr_q.delete();
                model_idle = 1'b1; exp_done = 1'b0; issued = 0; popped = 0;
            end else begin
                idle_now = model_idle;
                nxt_done = 1'b0;
                check(cmd_ready == idle_now, "cmd_ready", cmd_ready, idle_now);
                check(busy == !idle_now, "busy", busy, !idle_now);
                check(done == exp_done, "done", done, exp_done);
                if (mem_ren) begin
                    if (addr_q.size() == 0) check(1'b0, "unexpected_mem_ren", mem_raddr, 0);
                    else begin
                        ea = addr_q.pop_front();
                        check(mem_raddr == ea, "mem_raddr", mem_raddr, ea);
                    end
                    check(issued - popped < DEPTH, "read_credit", issued - popped, DEPTH - 1);
                    issued++;
                    if (ren_in_burst == 0) first_ren_cyc = cyc;
                    last_ren_cyc = cyc;
                    ren_in_burst++;
                end
                if (out_valid && byte_q.size() == 0) check(1'b0, "spurious_out_valid", out_data, 0);
                else if (out_valid && out_ready) begin
                    e = byte_q.pop_front();
                    check(out_data == e.d && out_last == e.l, "out_byte", {out_data, out_last}, {e.d, e.l});
                    popped++;
                    pops_in_burst++;
                    if (e.l) begin
                        model_idle = 1'b1;
                        nxt_done   = 1'b1;
                        done_cyc   = cyc + 1;
                    end
                end
                if (cmd_valid && idle_now) begin
                    accepts++;
                    acc_cyc = cyc;
                    ren_in_burst = 0;
                    pops_in_burst = 0;
                    if (cmd_len == '0) nxt_done = 1'b1;
                    else begin
                        model_idle = 1'b0;
                        for (int i = 0; i < int'(cmd_len); i++) begin
                            a = cmd_addr + AW'(i);
                            addr_q.push_back(a);
                            e.d = mem_byte(a);
                            e.l = (i == int'(cmd_len) - 1);
                            byte_q.push_back(e);
                        end
                    end
                end
                exp_done = nxt_done;
            end
        end
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input int l);
        int n0, t;
        n0 = accepts;
        t = 0;
        cmd_addr  = a;
        cmd_len   = LW'(l);
        cmd_valid = 1'b1;
        while (accepts == n0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (accepts == n0) check(1'b0, "accept_timeout", t, 300);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(model_idle && byte_q.size() == 0 && addr_q.size() == 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) check(1'b0, "drain_timeout", t, 3000);
        repeat (2) begin @(posedge clk); end
        #1;
    endtask

    task automatic stimulus();
        int t;
        logic [AW-1:0] ra;
        repeat (3) begin @(posedge clk); end
        #1 rst = 1'b0;

        rdy_mode = 0;
        start_burst(20'h00010, 5);
        wait_idle();
        check(first_ren_cyc == acc_cyc + 1, "first_ren_latency", first_ren_cyc - acc_cyc, 1);
        check(last_ren_cyc - first_ren_cyc == 4, "basic_throughput", last_ren_cyc - first_ren_cyc, 4);

        rdy_mode = 2;
        start_burst(20'h00200, 10);
        repeat (8) begin @(posedge clk); end
        #1;
        check(ren_in_burst == DEPTH, "backpressure_reads", ren_in_burst, DEPTH);
        check(pops_in_burst == 0 && out_valid, "backpressure_held", pops_in_burst, 0);
        rdy_mode = 0;
        wait_idle();
        check(ren_in_burst == 10, "backpressure_total", ren_in_burst, 10);

        start_burst(20'hFFFFE, 4);
        wait_idle();
        check(last_ren_cyc - first_ren_cyc == 3, "wrap_throughput", last_ren_cyc - first_ren_cyc, 3);

        start_burst(20'h12345, 0);
        wait_idle();
        check(ren_in_burst == 0, "zero_len_reads", ren_in_burst, 0);

        start_burst(20'h00300, 8);
        t = 0;
        while (pops_in_burst < 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check(pops_in_burst == 3, "pops_before_reset", pops_in_burst, 3);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); end
        #1 rst = 1'b0;
        start_burst(20'h00100, 2);
        wait_idle();

        // Second request is held during the first burst and must wait for its done cycle.
        start_burst(20'h00400, 6);
        start_burst(20'h55555, 3);
        check(acc_cyc == done_cyc, "accept_after_done", acc_cyc, done_cyc);
        wait_idle();

        rdy_mode = 1;
        for (int n = 0; n < 25; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? (20'hFFFF0 + AW'($urandom_range(0, 15))) : AW'($urandom);
            start_burst(ra, $urandom_range(0, 12));
        end
        wait_idle();
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
